seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider; the inverse of the team's 4x4 array multiplier. It takes an 8-bit dividend and a 4-bit divisor and returns an 8-bit quotient and a 4-bit remainder. It produces one quotient bit per clock through a start/busy/done handshake. It sits alongside the multiplier behind the ui_in/uo_out pin wrapper; muxing operands onto pins is the wrapper's job, not this block's.

Parameters:
DW, 8, dividend and quotient width in bits (>=2)
VW, 4, divisor and remainder width in bits (>=1, <=DW)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous active-high reset
start  input  1  request pulse; sampled only in IDLE or DONE
dividend  input  DW  unsigned dividend; sampled with an accepted start
divisor  input  VW  unsigned divisor; sampled with an accepted start
quotient  output  DW  result quotient; registered
remainder  output  VW  result remainder; registered
busy  output  1  high while a division is in progress (RUN)
done  output  1  single-cycle completion pulse (DONE)
div_by_zero  output  1  error flag for the most recent result

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous, active-high.
- On reset, every output is 0, the FSM is in IDLE and internal registers are 0.
- Reset asserted mid-operation aborts the division with no done pulse. Reset has priority over start.
- FSM states:
  - IDLE: busy=0, done=0. An accepted start goes to RUN if divisor!=0, or to DONE if divisor==0.
  - RUN: busy=1, done=0. It runs exactly DW iterations using down-counter cnt (width clog2(DW+1)). After the last iteration it goes to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Next state is IDLE, unless start=1 in that cycle, which is accepted exactly as in IDLE (back-to-back).
- Operand capture on an accepted start:
  - dividend is loaded into shift register a (DW bits).
  - divisor is latched into b (VW bits).
  - Partial remainder r (VW+1 bits) is cleared; cnt is set to DW.
- Each RUN cycle:
  - t = {r[VW-1:0], a[DW-1]}.
  - If t >= b: r = t - b and the new quotient bit is 1. Otherwise r = t and the new quotient bit is 0.
  - a shifts left, taking the new quotient bit into its LSB; cnt decrements.
  - All compares and subtracts are VW+1 bits wide, unsigned.
- Latency:
  - start is sampled at edge k. RUN covers edges k+1..k+DW.
  - quotient, remainder and div_by_zero update at edge k+DW, together with the entry to DONE.
  - done is high in the cycle after edge k+DW, i.e. DW+1 cycles after start is sampled (9 for the defaults).
- Divide by zero:
  - Skips RUN entirely; done rises 1 cycle after start.
  - quotient is all ones, remainder is 0, div_by_zero=1.
- A normal completion clears div_by_zero.
- Result outputs hold their value until the next completion. They do not change during RUN or IDLE.
- start while busy=1 is ignored. Input changes during RUN have no effect; operands are captured only at an accepted start.
- Result identity when divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- dividend < divisor gives quotient=0 and remainder=dividend.

Test Plan:
- dividend=200, divisor=7, start for 1 cycle -> busy for 8 cycles, then done pulse 9 cycles after start; quotient=28, remainder=4, div_by_zero=0.
- 255/15 then 5/9, with the second start asserted during the first done cycle -> 17 r0, then 0 r5; done pulses exactly 9 cycles apart with no IDLE gap.
- 13/0 -> done 1 cycle after start; quotient=255, remainder=0, div_by_zero=1. Next, 9/3 -> 3 r0 and div_by_zero clears.
- Start 100/3, assert start again with new operands 255/1 on cycles 3 and 5 of RUN -> ignored; result is 33 r1 at the normal time.
- Start 200/7, assert rst on cycle 4 of RUN -> next cycle all outputs 0, FSM in IDLE, no done pulse. A following 6/4 -> 1 r2.
- Random sweep of all 256x16 operand pairs -> quotient and remainder match the reference model, div_by_zero matches divisor==0, and every completion has latency 9 (or 1 for divide by zero).

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake. Divide by zero skips the iteration phase.
module seq_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [DW-1:0] r_a;
  logic [VW-1:0] r_b;
  logic [VW-1:0] r_rem;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_remout;
  logic          r_busy;
  logic          r_done;
  logic          r_dbz;

  logic [VW:0]   w_t;
  logic [VW:0]   w_diff;
  logic          w_ge;
  logic [VW-1:0] w_rem_next;
  logic [DW-1:0] w_a_next;

  // The partial remainder is always below the divisor, so only its low VW bits
  // are stored. t >= b holds when t already overflows VW bits, or when the
  // VW+1-bit difference shows no borrow.
  always_comb begin
    w_t        = {r_rem, r_a[DW-1]};
    w_diff     = w_t - {1'b0, r_b};
    w_ge       = w_t[VW] | ~w_diff[VW];
    w_rem_next = w_ge ? w_diff[VW-1:0] : w_t[VW-1:0];
    w_a_next   = {r_a[DW-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_remout <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a   <= dividend;
            r_b   <= divisor;
            r_rem <= '0;
            r_cnt <= CW'(DW);
            if (divisor == '0) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_quot   <= '1;
              r_remout <= '0;
              r_dbz    <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a   <= w_a_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_quot   <= w_a_next;
            r_remout <= w_rem_next;
            r_dbz    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_remout;
  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider; expected results are queued
// when a start is driven and compared when done pulses.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;
    int         lat;
    int         t0;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.DW(8), .VW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge and retire a scoreboard entry on done.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("latency", 32'(cyc - e.t0 + 1), 32'(e.lat));
      end
    end
  endtask

  task automatic do_start(input int a, input int b);
    exp_t e;
    dividend = 8'(a);
    divisor  = 4'(b);
    start    = 1'b1;
    if (b == 0) begin
      e.q = 8'hFF; e.r = 4'd0; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.q = 8'(a / b); e.r = 4'(a % b); e.dbz = 1'b0; e.lat = 9;
    end
    e.t0 = cyc + 1;
    sb.push_back(e);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_sb();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    tick();

    // 200/7: busy for 8 cycles, done 9 cycles after start
    do_start(200, 7);
    chk("busy_first", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
    end
    tick();
    chk("busy_done", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) tick();
    chk("done_single", 32'(done), 32'd0);
    chk("hold_quotient", 32'(quotient), 32'd28);
    chk("hold_remainder", 32'(remainder), 32'd4);

    // back-to-back: second start issued during the first done cycle
    do_start(255, 15);
    wait_sb();
    chk("b2b_done_cycle", 32'(done), 32'd1);
    do_start(5, 9);
    chk("b2b_no_gap", 32'(busy), 32'd1);
    wait_sb();
    tick();

    // divide by zero, then a normal result clears the flag
    do_start(13, 0);
    tick();
    do_start(9, 3);
    wait_sb();
    tick();

    // start during RUN is ignored
    do_start(100, 3);
    tick();
    tick();
    dividend = 8'd255; divisor = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sb();
    tick();

    // reset mid-RUN aborts without a done pulse
    do_start(200, 7);
    repeat (3) tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    chk("abort_quotient", 32'(quotient), 32'd0);
    chk("abort_remainder", 32'(remainder), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    repeat (12) tick();
    do_start(6, 4);
    wait_sb();
    tick();

    // every operand pair, issued back-to-back
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_start(a, b);
        wait_sb();
      end
    end
    repeat (3) tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
